// File: rtl/full_adder_pkg.sv
// full_adder_pkg: cell-style selectors and limits shared by the adder files
package full_adder_pkg;
    localparam int IMPL_GATE   = 0;
    localparam int IMPL_DF_XOR = 1;
    localparam int IMPL_DF_SOP = 2;
    localparam int IMPL_BEHAV  = 3;
    localparam int MAX_WIDTH   = 64;
endpackage

// File: rtl/full_adder_reg_if.sv
// full_adder_reg_if: operand/result bundle between a producer and the registered adder
interface full_adder_reg_if #(parameter int WIDTH = 1);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;
    modport master (output in_valid, A, B, Cin, input S, Cout, out_valid);
    modport slave (input in_valid, A, B, Cin, output S, Cout, out_valid);
endinterface

// File: rtl/full_adder_reg_fa_cell.sv
// fa_cell: 1-bit full adder with a selectable internal description style
module fa_cell
    import full_adder_pkg::*;
#(
    parameter int IMPL = IMPL_GATE
) (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    if (IMPL == IMPL_GATE) begin : g_gate
        logic ab_x, ab_a, xc_a;
        xor g_x0 (ab_x, a, b);
        xor g_x1 (s, ab_x, ci);
        and g_a0 (ab_a, a, b);
        and g_a1 (xc_a, ab_x, ci);
        or  g_o0 (co, ab_a, xc_a);
    end else if (IMPL == IMPL_DF_XOR) begin : g_df_xor
        assign s  = a ^ b ^ ci;
        assign co = (a & b) | (a & ci) | (b & ci);
    end else if (IMPL == IMPL_DF_SOP) begin : g_df_sop
        assign s  = (~a & ~b & ci) | (~a & b & ~ci) | (a & ~b & ~ci) | (a & b & ci);
        assign co = (a & b & ~ci) | (a & ~b & ci) | (~a & b & ci) | (a & b & ci);
    end else begin : g_behav
        assign {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    end
endmodule

// File: rtl/full_adder_reg.sv
// full_adder_reg: ripple-carry adder with a one-cycle registered result and valid flag
module full_adder_reg
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int IMPL  = IMPL_GATE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    full_adder_reg_if.slave        bus
);
    logic [WIDTH-1:0] s_comb, s_d, s_q;
    logic             c_out, cout_d, cout_q, valid_d, valid_q;

    if (IMPL < IMPL_GATE || IMPL > IMPL_BEHAV) begin : g_bad_impl
        $error("full_adder_reg: IMPL must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("full_adder_reg: WIDTH must be 1..64");
    end

    if (IMPL == IMPL_BEHAV) begin : g_behav
        assign {c_out, s_comb} = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
    end else begin : g_chain
        logic [WIDTH:0] c;
        assign c[0] = bus.Cin;
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            fa_cell #(.IMPL(IMPL)) u_cell (
                .a  (bus.A[i]),
                .b  (bus.B[i]),
                .ci (c[i]),
                .s  (s_comb[i]),
                .co (c[i+1])
            );
        end
        assign c_out = c[WIDTH];
    end

    // capture a new result on valid input, otherwise hold it and drop the valid flag
    always_comb begin
        s_d     = bus.in_valid ? s_comb : s_q;
        cout_d  = bus.in_valid ? c_out : cout_q;
        valid_d = bus.in_valid;
    end

    // output register stage, cleared asynchronously so an in-flight result is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_full_adder_reg.sv
// tb_full_adder_reg: vector tables, corner sequences and random equivalence for full_adder_reg
module tb_full_adder_reg;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic vld = 1'b0;
    logic cin = 1'b0;
    logic a1 = 1'b0, b1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, s4;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0] s1, co1, ov1, co16, ov16;
    logic [15:0] s16 [4];
    logic co4, ov4, co8, ov8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_w1
        full_adder_reg_if #(.WIDTH(1)) bus ();
        assign bus.in_valid = vld;
        assign bus.A = a1;
        assign bus.B = b1;
        assign bus.Cin = cin;
        assign s1[k] = bus.S;
        assign co1[k] = bus.Cout;
        assign ov1[k] = bus.out_valid;
        full_adder_reg #(.WIDTH(1), .IMPL(k)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end

    for (genvar k = 0; k < 4; k++) begin : g_w16
        full_adder_reg_if #(.WIDTH(16)) bus ();
        assign bus.in_valid = vld;
        assign bus.A = a16;
        assign bus.B = b16;
        assign bus.Cin = cin;
        assign s16[k] = bus.S;
        assign co16[k] = bus.Cout;
        assign ov16[k] = bus.out_valid;
        full_adder_reg #(.WIDTH(16), .IMPL(k)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end

    full_adder_reg_if #(.WIDTH(8)) bus8 ();
    assign bus8.in_valid = vld;
    assign bus8.A = a8;
    assign bus8.B = b8;
    assign bus8.Cin = cin;
    assign s8 = bus8.S;
    assign co8 = bus8.Cout;
    assign ov8 = bus8.out_valid;
    full_adder_reg #(.WIDTH(8), .IMPL(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    full_adder_reg_if #(.WIDTH(4)) bus4 ();
    assign bus4.in_valid = vld;
    assign bus4.A = a4;
    assign bus4.B = b4;
    assign bus4.Cin = cin;
    assign s4 = bus4.S;
    assign co4 = bus4.Cout;
    assign ov4 = bus4.out_valid;
    full_adder_reg #(.WIDTH(4), .IMPL(0)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t t1 [8];
        vec_t t8 [3];
        logic [15:0] exp_s;
        logic exp_co;
        logic [31:0] sum;
        t1 = '{'{0, 0, 0, 0, 0}, '{0, 0, 1, 1, 0}, '{0, 1, 0, 1, 0}, '{0, 1, 1, 0, 1},
               '{1, 0, 0, 1, 0}, '{1, 0, 1, 0, 1}, '{1, 1, 0, 0, 1}, '{1, 1, 1, 1, 1}};
        t8 = '{'{8'hFF, 8'h00, 1, 8'h00, 1}, '{8'hFF, 8'hFF, 1, 8'hFF, 1},
               '{8'h00, 8'h00, 0, 8'h00, 0}};
        #1 rst_n = 1'b0;
        #1;
        chk("reset_s8", 32'(s8), 0);
        chk("reset_co8", 32'(co8), 0);
        chk("reset_ov8", 32'(ov8), 0);
        chk("reset_ov1", 32'(ov1), 0);
        step();
        step();
        chk("reset_held_ov8", 32'(ov8), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a1 = t1[i].a[0];
            b1 = t1[i].b[0];
            cin = t1[i].c;
            vld = 1'b1;
            step();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("w1_s_v%0d_impl%0d", i, k), 32'(s1[k]), 32'(t1[i].s[0]));
                chk($sformatf("w1_co_v%0d_impl%0d", i, k), 32'(co1[k]), 32'(t1[i].co));
                chk($sformatf("w1_ov_v%0d_impl%0d", i, k), 32'(ov1[k]), 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            a8 = t8[i].a;
            b8 = t8[i].b;
            cin = t8[i].c;
            vld = 1'b1;
            step();
            chk($sformatf("w8_s_v%0d", i), 32'(s8), 32'(t8[i].s));
            chk($sformatf("w8_co_v%0d", i), 32'(co8), 32'(t8[i].co));
        end
        a8 = 8'd3;
        b8 = 8'd4;
        cin = 1'b0;
        vld = 1'b1;
        step();
        chk("gate_s_first", 32'(s8), 7);
        chk("gate_ov_first", 32'(ov8), 1);
        vld = 1'b0;
        a8 = 8'd9;
        step();
        chk("gate_s_hold", 32'(s8), 7);
        chk("gate_co_hold", 32'(co8), 0);
        chk("gate_ov_drop", 32'(ov8), 0);
        a4 = 4'd5;
        b4 = 4'd6;
        cin = 1'b0;
        vld = 1'b1;
        step();
        chk("b2b_s_first", 32'(s4), 11);
        chk("b2b_co_first", 32'(co4), 0);
        chk("b2b_ov_first", 32'(ov4), 1);
        a4 = 4'd15;
        b4 = 4'd1;
        step();
        chk("b2b_s_second", 32'(s4), 0);
        chk("b2b_co_second", 32'(co4), 1);
        chk("b2b_ov_second", 32'(ov4), 1);
        a8 = 8'h12;
        b8 = 8'h34;
        cin = 1'b1;
        step();
        chk("mid_pre_s8", 32'(s8), 32'h47);
        chk("mid_pre_ov8", 32'(ov8), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_async_s8", 32'(s8), 0);
        chk("mid_async_co8", 32'(co8), 0);
        chk("mid_async_ov8", 32'(ov8), 0);
        chk("mid_async_ov16", 32'(ov16), 0);
        step();
        chk("mid_held_s8", 32'(s8), 0);
        chk("mid_held_ov8", 32'(ov8), 0);
        rst_n = 1'b1;
        a8 = 8'd10;
        b8 = 8'd20;
        cin = 1'b1;
        #1;
        chk("release_no_edge_ov8", 32'(ov8), 0);
        step();
        chk("release_first_s8", 32'(s8), 31);
        chk("release_first_ov8", 32'(ov8), 1);
        exp_s = '0;
        exp_co = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            vld = (i == 0) || ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cin = 1'($urandom);
            sum = 32'(a16) + 32'(b16) + 32'(cin);
            if (vld) begin
                exp_s = sum[15:0];
                exp_co = sum[16];
            end
            step();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rnd%0d_s_impl%0d", i, k), 32'(s16[k]), 32'(exp_s));
                chk($sformatf("rnd%0d_co_impl%0d", i, k), 32'(co16[k]), 32'(exp_co));
                chk($sformatf("rnd%0d_ov_impl%0d", i, k), 32'(ov16[k]), 32'(vld));
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
